// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: sequencing controller for a Goldschmidt floating-point divider.
// Walks the datapath through the initial approximation pair, NUM_ITER refinement
// pairs and, optionally, a two-step remainder computation.
// Optional feature macro: FPDIV_CTRL_REM_EN (defined -> REM_Q/REM_D steps are
// sequenced; undefined -> the last refinement goes straight to DONE and en_rem
// stays low).
// NUM_ITER is legal in 1..7 so the 3-bit iteration counter never wraps.
module fpdiv_ctrl #(
    parameter int NUM_ITER = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rm,
    output logic       rm_q,
    output logic       busy,
    output logic       done,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic [1:0] sel_mux3,
    output logic [2:0] sel_mux5
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT_N = 3'd1,
        INIT_D = 3'd2,
        ITER_N = 3'd3,
        ITER_D = 3'd4,
        REM_Q  = 3'd5,
        REM_D  = 3'd6,
        DONE   = 3'd7
    } state_e;

    localparam logic [3:0] ITER_LIMIT = 4'(NUM_ITER);

    // Operand-select encodings shared with the datapath
    localparam logic [2:0] A_NUM  = 3'b000;
    localparam logic [2:0] A_DEN  = 3'b001;
    localparam logic [2:0] A_AREG = 3'b010;
    localparam logic [2:0] A_BREG = 3'b011;
    localparam logic [2:0] A_QMUL = 3'b100;
    localparam logic [1:0] B_APPX = 2'b00;
    localparam logic [1:0] B_CREG = 2'b01;
    localparam logic [1:0] B_QUOT = 2'b10;

    state_e     state_q, state_d;
    logic [2:0] iter_q, iter_d;
    logic [3:0] iterInc;
    logic       accept;

    // Output vector layout: {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux5}
    function automatic logic [9:0] decodeOutputs(input state_e s);
        logic [9:0] o;
        o = '0;
        case (s)
            INIT_N: o = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, B_APPX, A_NUM};
            INIT_D: o = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, B_APPX, A_DEN};
            ITER_N: o = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, B_CREG, A_AREG};
            ITER_D: o = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, B_CREG, A_BREG};
`ifdef FPDIV_CTRL_REM_EN
            REM_Q:  o = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, B_QUOT, A_AREG};
            REM_D:  o = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, B_QUOT, A_QMUL};
`endif
            DONE:   o = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B_APPX, A_NUM};
            default: o = '0;
        endcase
        return o;
    endfunction

    assign iterInc = {1'b0, iter_q} + 4'd1;
    assign accept  = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state and iteration-counter logic; start is only honoured in IDLE/DONE
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE:   if (start) state_d = INIT_N;
            INIT_N: state_d = INIT_D;
            INIT_D: begin
                state_d = ITER_N;
                iter_d  = 3'd0;
            end
            ITER_N: state_d = ITER_D;
            ITER_D: begin
                iter_d = iterInc[2:0];
                if (iterInc < ITER_LIMIT) begin
                    state_d = ITER_N;
                end else begin
`ifdef FPDIV_CTRL_REM_EN
                    state_d = REM_Q;
`else
                    state_d = DONE;
`endif
                end
            end
            REM_Q:  state_d = REM_D;
            REM_D:  state_d = DONE;
            DONE:   state_d = start ? INIT_N : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter, captured rounding mode and registered Moore outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            iter_q   <= 3'd0;
            rm_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            en_a     <= 1'b0;
            en_b     <= 1'b0;
            en_rem   <= 1'b0;
            sel_mux3 <= 2'b00;
            sel_mux5 <= 3'b000;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            if (accept) begin
                rm_q <= rm;
            end
            {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux5} <= decodeOutputs(state_d);
        end
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: randomized self-checking bench for fpdiv_ctrl.
// Two instances (NUM_ITER=5 and NUM_ITER=1) share one stimulus stream; each is
// compared every cycle against a queue of expected output vectors built from
// the operation's step list whenever an accept is predicted.
// Honours FPDIV_CTRL_REM_EN the same way the design does.
module tb_fpdiv_ctrl;

`ifdef FPDIV_CTRL_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    localparam logic [9:0] IDLE_V = 10'd0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic rm    = 1'b0;

    int checkCount = 0;
    int errCount   = 0;

    event midReset;

    initial forever #5 clk = ~clk;

    // Vector layout: {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux5}
    function automatic logic [9:0] mkOut(input bit b, input bit d, input bit a, input bit bb,
                                         input bit r, input logic [1:0] s3, input logic [2:0] s5);
        return {b, d, a, bb, r, s3, s5};
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] actual, input logic [9:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            start = s;
            rm    = r;
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int N = (g == 0) ? 5 : 1;

        logic       rmQ, busy, done, enA, enB, enRem;
        logic [1:0] selMux3;
        logic [2:0] selMux5;
        logic [9:0] outV;
        logic [9:0] expQ[$];
        logic [9:0] cur   = 10'd0;
        logic       expRm = 1'b0;

        fpdiv_ctrl #(.NUM_ITER(N)) dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .rm       (rm),
            .rm_q     (rmQ),
            .busy     (busy),
            .done     (done),
            .en_a     (enA),
            .en_b     (enB),
            .en_rem   (enRem),
            .sel_mux3 (selMux3),
            .sel_mux5 (selMux5)
        );

        assign outV = {busy, done, enA, enB, enRem, selMux3, selMux5};

        // Reference model: an accept enqueues the whole operation's step list
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                expQ.delete();
                cur   = IDLE_V;
                expRm = 1'b0;
            end else begin
                if (start && (cur == IDLE_V || cur[8])) begin
                    expRm = rm;
                    expQ.push_back(mkOut(1, 0, 1, 0, 0, 2'b00, 3'b000));
                    expQ.push_back(mkOut(1, 0, 0, 1, 0, 2'b00, 3'b001));
                    for (int i = 0; i < N; i++) begin
                        expQ.push_back(mkOut(1, 0, 1, 0, 0, 2'b01, 3'b010));
                        expQ.push_back(mkOut(1, 0, 0, 1, 0, 2'b01, 3'b011));
                    end
                    if (REM_EN) begin
                        expQ.push_back(mkOut(1, 0, 0, 0, 1, 2'b10, 3'b010));
                        expQ.push_back(mkOut(1, 0, 0, 0, 1, 2'b10, 3'b100));
                    end
                    expQ.push_back(mkOut(0, 1, 0, 0, 0, 2'b00, 3'b000));
                end
                cur = (expQ.size() != 0) ? expQ.pop_front() : IDLE_V;
            end
        end

        // Per-cycle comparison away from the active edge
        always @(negedge clk) begin
            checkOutput($sformatf("out_n%0d", N), outV, cur);
            checkOutput($sformatf("rmq_n%0d", N), {9'd0, rmQ}, {9'd0, expRm});
            checkOutput($sformatf("onehot_n%0d", N),
                        {9'd0, (int'(enA) + int'(enB) + int'(enRem)) <= 1}, 10'd1);
        end

        // Asynchronous reset must clear outputs before the next clock edge
        always @(midReset) begin
            checkOutput($sformatf("asyncrst_n%0d", N), outV, IDLE_V);
            checkOutput($sformatf("asyncrst_rmq_n%0d", N), {9'd0, rmQ}, 10'd0);
        end
    end

    initial begin
        #1 reset = 1'b0;
        #27 reset = 1'b1;

        $display("[TB] single start pulse");
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] start held high, rm randomized");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1);
        end
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] start pulse while busy");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] random start/rm");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1);
        end
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] mid-cycle reset during ITER_D");
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 4);
        #3 reset = 1'b0;
        #1 ->midReset;
        #3 reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter: NUM_ITER, default 5, number of Goldschmidt refinement iterations after the initial-approximation pair (legal 1..7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a division sequence; sampled on rising clk.
REQ-005 rm  input  1  rounding mode for this operation.
REQ-006 rm_q  output  1  rm captured when start is accepted; held until the next accept.
REQ-007 busy  output  1  high while a sequence is in progress.
REQ-008 done  output  1  one-cycle pulse marking sequence completion.
REQ-009 en_a  output  1  load enable, numerator-path register.
REQ-010 en_b  output  1  load enable, denominator-path register.
REQ-011 en_rem  output  1  load enable, remainder register.
REQ-012 sel_mux3  output  2  multiplier operand-B select: 00 initial approximation, 01 C register, 10 quotient.
REQ-013 sel_mux5  output  3  multiplier operand-A select: 000 numerator, 001 denominator, 010 A reg, 011 B reg, 100 quotient multiplicand.

Function
REQ-014 FSM states: IDLE, INIT_N, INIT_D, ITER_N, ITER_D, REM_Q, REM_D, DONE.
REQ-015 Outputs are Moore, decoded from the state register only; no output depends combinationally on start or rm.
REQ-016 IDLE: en_a=en_b=en_rem=0, sel_mux5=000, sel_mux3=00, busy=0, done=0.
REQ-017 IDLE -> INIT_N when start=1; rm_q <= rm on that edge; otherwise remain in IDLE.
REQ-018 INIT_N: sel_mux5=000, sel_mux3=00, en_a=1; always -> INIT_D.
REQ-019 INIT_D: sel_mux5=001, sel_mux3=00, en_b=1; iteration counter cleared to 0; always -> ITER_N.
REQ-020 ITER_N: sel_mux5=010, sel_mux3=01, en_a=1; always -> ITER_D.
REQ-021 ITER_D: sel_mux5=011, sel_mux3=01, en_b=1; counter increments; -> ITER_N when counter+1 < NUM_ITER, else -> REM_Q (or DONE, see REQ-030).
REQ-022 REM_Q: sel_mux5=010, sel_mux3=10, en_rem=1; always -> REM_D.
REQ-023 REM_D: sel_mux5=100, sel_mux3=10, en_rem=1; always -> DONE.
REQ-024 DONE: done=1, busy=0, all enables 0, selects 000/00; -> INIT_N if start=1 (back-to-back accept, rm_q recaptured), else -> IDLE.
REQ-025 busy=1 in every state except IDLE and DONE; at most one of en_a/en_b/en_rem is high in any cycle.
REQ-026 start while busy=1 is ignored; no queuing.
REQ-027 Latency (REM enabled): start accepted at edge 0 -> done high in cycle 2*NUM_ITER+5 (15 for default).
REQ-028 Counter is 3 bits; never wraps within a sequence for legal NUM_ITER.

Reset
REQ-029 reset low asynchronously forces IDLE, counter=0, rm_q=0, all outputs to IDLE values, including mid-sequence; first accept possible on first rising edge after reset deasserts.

Configuration
REQ-030 Macro FPDIV_CTRL_REM_EN: defined -> REM_Q/REM_D included as above; undefined -> ITER_D final exit goes directly to DONE, en_rem held 0, latency 2*NUM_ITER+3 (13 default).

Verification
REQ-031 Reset low 27 ns, start pulse at one edge, NUM_ITER=5, REM_EN defined -> per-cycle sel_mux5 sequence 000,001,(010,011)x5,010,100 then done=1 exactly once at cycle 15.
REQ-032 Same stimulus, REM_EN undefined -> en_rem never 1, done at cycle 13, sequence ends after fifth 011.
REQ-033 start held high continuously -> done pulses every 15 cycles with no IDLE gap; rm toggled each accept -> rm_q follows value sampled at each accept.
REQ-034 start pulsed during ITER_N of iteration 3 -> ignored; single done at cycle 15.
REQ-035 reset driven low mid-cycle during ITER_D -> outputs return to IDLE values immediately (before next edge); next start produces a full 15-cycle sequence.
REQ-036 NUM_ITER=1 -> sequence 000,001,010,011,010,100, done at cycle 7; assertion en_a+en_b+en_rem<=1 checked every cycle in all runs.
